// File: rtl/upsample_sched.sv
// upsample_sched: symbol-to-sample scheduler (zero-stuff / sample-hold) with filter flush.
// Rev 1.0
`default_nettype none

module upsample_sched #(
  parameter int UPS       = 4,
  parameter int PHASE_W   = 2,
  parameter int FLUSH_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_hold,
  input  logic               flush_req,
  input  logic               in_valid,
  input  logic [3:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [3:0]         out_data,
  output logic [PHASE_W-1:0] out_phase,
  output logic               out_sym_start,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [PHASE_W-1:0] LAST_PH    = PHASE_W'(UPS - 1);
  localparam logic [7:0]         FLUSH_LAST = 8'(FLUSH_LEN);

  state_t               state, state_nx;
  logic [3:0]           sym_reg, sym_reg_nx;
  logic                 hold_mode, hold_mode_nx;
  logic                 flush_pend, flush_pend_nx;
  logic [7:0]           flush_cnt, flush_cnt_nx;
  logic                 out_valid_nx;
  logic [3:0]           out_data_nx;
  logic [PHASE_W-1:0]   out_phase_nx;
  logic                 out_sym_start_nx;
  logic                 last_ph;
  logic                 xfer;

  assign last_ph  = (out_phase == LAST_PH);
  // A flush request in the last-phase cycle must already block the handshake.
  assign in_ready = en & ~rst &
                    ((state == IDLE) |
                     ((state == RUN) & last_ph & ~flush_pend & ~flush_req));
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_nx         = state;
    sym_reg_nx       = sym_reg;
    hold_mode_nx     = hold_mode;
    flush_pend_nx    = flush_pend;
    flush_cnt_nx     = flush_cnt;
    out_valid_nx     = out_valid;
    out_data_nx      = out_data;
    out_phase_nx     = out_phase;
    out_sym_start_nx = out_sym_start;

    if (xfer) begin
      state_nx         = RUN;
      sym_reg_nx       = in_data;
      hold_mode_nx     = cfg_hold;
      out_valid_nx     = 1'b1;
      out_data_nx      = in_data;
      out_phase_nx     = '0;
      out_sym_start_nx = 1'b1;
    end else if (en) begin
      case (state)
        IDLE: begin
          out_valid_nx     = 1'b0;
          out_data_nx      = 4'd0;
          out_phase_nx     = '0;
          out_sym_start_nx = 1'b0;
        end
        RUN: begin
          out_sym_start_nx = 1'b0;
          out_valid_nx     = 1'b1;
          if (flush_req) flush_pend_nx = 1'b1;
          if (!last_ph) begin
            out_phase_nx = out_phase + PHASE_W'(1);
            out_data_nx  = hold_mode ? sym_reg : 4'd0;
          end else begin
            // Underrun and requested end-of-stream both drain the filter.
            state_nx      = FLUSH;
            flush_pend_nx = 1'b0;
            flush_cnt_nx  = 8'd1;
            out_data_nx   = 4'd0;
            out_phase_nx  = '0;
          end
        end
        FLUSH: begin
          out_sym_start_nx = 1'b0;
          out_data_nx      = 4'd0;
          if (flush_cnt == FLUSH_LAST) begin
            state_nx     = IDLE;
            flush_cnt_nx = 8'd0;
            out_valid_nx = 1'b0;
            out_phase_nx = '0;
          end else begin
            flush_cnt_nx = flush_cnt + 8'd1;
            out_valid_nx = 1'b1;
            out_phase_nx = last_ph ? '0 : out_phase + PHASE_W'(1);
          end
        end
        default: begin
          state_nx     = IDLE;
          out_valid_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sym_reg       <= 4'd0;
      hold_mode     <= 1'b0;
      flush_pend    <= 1'b0;
      flush_cnt     <= 8'd0;
      out_valid     <= 1'b0;
      out_data      <= 4'd0;
      out_phase     <= '0;
      out_sym_start <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      sym_reg       <= sym_reg_nx;
      hold_mode     <= hold_mode_nx;
      flush_pend    <= flush_pend_nx;
      flush_cnt     <= flush_cnt_nx;
      out_valid     <= out_valid_nx;
      out_data      <= out_data_nx;
      out_phase     <= out_phase_nx;
      out_sym_start <= out_sym_start_nx;
      busy          <= (state_nx != IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_upsample_sched.sv
// tb_upsample_sched: scoreboard bench for upsample_sched (UPS=4, FLUSH_LEN=8).
`default_nettype none

module tb_upsample_sched;

  localparam int UPS       = 4;
  localparam int PHASE_W   = 2;
  localparam int FLUSH_LEN = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b1;
  logic               cfg_hold = 1'b0;
  logic               flush_req = 1'b0;
  logic               in_valid = 1'b0;
  logic [3:0]         in_data = 4'd0;
  logic               in_ready;
  logic               out_valid;
  logic [3:0]         out_data;
  logic [PHASE_W-1:0] out_phase;
  logic               out_sym_start;
  logic               busy;

  typedef struct packed {
    logic [3:0]         d;
    logic [PHASE_W-1:0] ph;
    logic               st;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  upsample_sched #(.UPS(UPS), .PHASE_W(PHASE_W), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_hold(cfg_hold), .flush_req(flush_req),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_phase(out_phase),
    .out_sym_start(out_sym_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Samples are consumed downstream only on enabled cycles.
  always @(negedge clk) begin
    if (!rst && en && out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got d=%0h ph=%0d st=%0b expected none at %0t",
                 out_data, out_phase, out_sym_start, $time);
      end else begin
        mon_e = q.pop_front();
        check("sample", {25'd0, out_data, out_phase, out_sym_start}, {25'd0, mon_e});
      end
    end
    if (!rst && in_ready && busy) check("in_ready_phase", 32'(out_phase), 32'(UPS - 1));
  end

  task automatic push_sym(input logic [3:0] d, input logic hold);
    q.push_back('{d: d, ph: 2'd0, st: 1'b1});
    for (int p = 1; p < UPS; p++)
      q.push_back('{d: (hold ? d : 4'd0), ph: PHASE_W'(p), st: 1'b0});
  endtask

  task automatic push_flush();
    for (int i = 0; i < FLUSH_LEN; i++)
      q.push_back('{d: 4'd0, ph: PHASE_W'(i % UPS), st: 1'b0});
  endtask

  // Waits for in_ready, then lets the transfer edge pass; reports busy seen at acceptance.
  task automatic wait_hs(output logic busy_at_hs);
    int n = 0;
    busy_at_hs = 1'bx;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: got no in_ready expected in_ready=1 at %0t", $time);
    end
    busy_at_hs = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy !== 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_phase", 32'(out_phase), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
  endtask

  logic b;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {28'd0, out_data}, 32'd0);
    check("rst_out_phase", 32'(out_phase), 32'd0);
    check("rst_sym_start", {31'd0, out_sym_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Single zero-stuffed symbol, then full flush.
    push_sym(4'hA, 1'b0);
    push_flush();
    cfg_hold = 1'b0; in_data = 4'hA; in_valid = 1'b1;
    wait_hs(b);
    check("idle_accept_busy", {31'd0, b}, 32'd0);
    in_valid = 1'b0;
    drain();

    // Back-to-back held symbols with in_valid held high.
    push_sym(4'h3, 1'b1);
    cfg_hold = 1'b1; in_data = 4'h3; in_valid = 1'b1;
    wait_hs(b);
    in_data = 4'h5;
    push_sym(4'h5, 1'b1);
    push_flush();
    wait_hs(b);
    check("b2b_accept_busy", {31'd0, b}, 32'd1);
    in_valid = 1'b0;
    drain();

    // flush_req at phase 1; pending input only accepted from IDLE.
    push_sym(4'h7, 1'b0);
    push_flush();
    cfg_hold = 1'b0; in_data = 4'h7; in_valid = 1'b1;
    wait_hs(b);
    in_data = 4'h9;
    push_sym(4'h9, 1'b0);
    push_flush();
    @(posedge clk); #1;
    check("flush_at_phase1", 32'(out_phase), 32'd1);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    wait_hs(b);
    check("flush_accept_from_idle", {31'd0, b}, 32'd0);
    in_valid = 1'b0;
    drain();

    // Clock-enable freeze at phase 2.
    push_sym(4'hC, 1'b1);
    push_flush();
    cfg_hold = 1'b1; in_data = 4'hC; in_valid = 1'b1;
    wait_hs(b);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("freeze_phase", 32'(out_phase), 32'd2);
      check("freeze_data", {28'd0, out_data}, 32'hC);
      check("freeze_valid", {31'd0, out_valid}, 32'd1);
      check("freeze_in_ready", {31'd0, in_ready}, 32'd0);
    end
    en = 1'b1;
    drain();

    // Reset at phase 2: no flush samples afterwards.
    q.push_back('{d: 4'h6, ph: 2'd0, st: 1'b1});
    q.push_back('{d: 4'h6, ph: 2'd1, st: 1'b0});
    cfg_hold = 1'b1; in_data = 4'h6; in_valid = 1'b1;
    wait_hs(b);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {28'd0, out_data}, 32'd0);
    check("midrst_out_phase", 32'(out_phase), 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check("midrst_no_flush_busy", {31'd0, busy}, 32'd0);
    check("midrst_queue_empty", 32'(q.size()), 32'd0);
    q.delete();

    // cfg_hold change mid-symbol applies to the next symbol only.
    push_sym(4'h2, 1'b0);
    cfg_hold = 1'b0; in_data = 4'h2; in_valid = 1'b1;
    wait_hs(b);
    in_data = 4'hB;
    push_sym(4'hB, 1'b1);
    push_flush();
    @(posedge clk); #1;
    cfg_hold = 1'b1;
    wait_hs(b);
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
